// File: rtl/cpu_pkg.sv
// Shared RV32I decode constants and ALU operation encoding for the execute unit.
package cpu_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

endpackage

// File: rtl/cpu_regfile.sv
// 32x32 register file: x0 reads zero, two operand read ports plus a debug port,
// one synchronous write port, asynchronous active-low clear.
module cpu_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_addr,
  output logic [31:0] rs1_data,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs2_data,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] mem [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      mem[waddr] <= wdata;
    end
  end

  // Entry 0 is only ever cleared, but the read guard keeps x0 at zero regardless.
  assign rs1_data = (rs1_addr == 5'd0) ? '0 : mem[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : mem[rs2_addr];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/cpu_exec.sv
// Single-cycle RV32I execute/writeback: decode, operand read, ALU and register
// write on the next rising edge. Branches, jumps and memory ops are NOPs here.
module cpu_exec
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] f_instr,
  input  logic [31:0] f_pc,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  logic        legal;
  alu_op_e     alu_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_result;
  logic [4:0]  shamt;

  assign opcode = f_instr[6:0];
  assign rd     = f_instr[11:7];
  assign funct3 = f_instr[14:12];
  assign rs1    = f_instr[19:15];
  assign rs2    = f_instr[24:20];
  assign funct7 = f_instr[31:25];
  assign imm_i  = {{20{f_instr[31]}}, f_instr[31:20]};
  assign imm_u  = {f_instr[31:12], 12'b0};

  cpu_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1),
    .rs1_data (rs1_data),
    .rs2_addr (rs2),
    .rs2_data (rs2_data),
    .dbg_addr (dbg_raddr),
    .dbg_data (dbg_rdata),
    .we       (wb_en),
    .waddr    (rd),
    .wdata    (alu_result)
  );

  // LUI and AUIPC reuse the adder: LUI adds the U-immediate to zero.
  always_comb begin
    legal  = 1'b0;
    alu_op = ALU_ADD;
    op_a   = rs1_data;
    op_b   = imm_i;
    case (opcode)
      OPC_LUI: begin
        legal = 1'b1;
        op_a  = '0;
        op_b  = imm_u;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        op_a  = f_pc;
        op_b  = imm_u;
      end
      OPC_OP_IMM: begin
        op_b = imm_i;
        case (funct3)
          F3_ADD:  begin legal = 1'b1; alu_op = ALU_ADD;  end
          F3_SLT:  begin legal = 1'b1; alu_op = ALU_SLT;  end
          F3_SLTU: begin legal = 1'b1; alu_op = ALU_SLTU; end
          F3_XOR:  begin legal = 1'b1; alu_op = ALU_XOR;  end
          F3_OR:   begin legal = 1'b1; alu_op = ALU_OR;   end
          F3_AND:  begin legal = 1'b1; alu_op = ALU_AND;  end
          F3_SLL: begin
            legal  = (funct7 == F7_BASE);
            alu_op = ALU_SLL;
          end
          F3_SR: begin
            legal  = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            alu_op = f_instr[30] ? ALU_SRA : ALU_SRL;
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_OP: begin
        op_b = rs2_data;
        if (funct7 == F7_BASE) begin
          legal = 1'b1;
          case (funct3)
            F3_ADD:  alu_op = ALU_ADD;
            F3_SLL:  alu_op = ALU_SLL;
            F3_SLT:  alu_op = ALU_SLT;
            F3_SLTU: alu_op = ALU_SLTU;
            F3_XOR:  alu_op = ALU_XOR;
            F3_SR:   alu_op = ALU_SRL;
            F3_OR:   alu_op = ALU_OR;
            default: alu_op = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == F3_ADD) begin
            legal  = 1'b1;
            alu_op = ALU_SUB;
          end else if (funct3 == F3_SR) begin
            legal  = 1'b1;
            alu_op = ALU_SRA;
          end
        end
      end
      default: legal = 1'b0;
    endcase
  end

  assign shamt = op_b[4:0];

  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD:  alu_result = op_a + op_b;
      ALU_SUB:  alu_result = op_a - op_b;
      ALU_SLL:  alu_result = op_a << shamt;
      ALU_SLT:  alu_result = {31'b0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_result = {31'b0, op_a < op_b};
      ALU_XOR:  alu_result = op_a ^ op_b;
      ALU_SRL:  alu_result = op_a >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(op_a) >>> shamt);
      ALU_OR:   alu_result = op_a | op_b;
      ALU_AND:  alu_result = op_a & op_b;
      default:  alu_result = '0;
    endcase
  end

  assign wb_en   = legal && (rd != 5'd0);
  assign wb_rd   = rd;
  assign wb_data = alu_result;

endmodule

// File: tb/tb_cpu_exec.sv
// Self-checking bench for cpu_exec: expected writebacks are queued when an
// instruction is driven and compared against the debug read port after the edge.
module tb_cpu_exec;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] f_instr = '0;
  logic [31:0] f_pc = '0;
  logic [4:0]  dbg_raddr = '0;
  logic [31:0] dbg_rdata;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ref_regs [32];
  int          n_checks = 0;
  int          n_fail = 0;

  cpu_exec dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .f_instr   (f_instr),
    .f_pc      (f_pc),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata),
    .wb_en     (wb_en),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_u(input logic [6:0] opc, input logic [4:0] rd,
                                        input logic [19:0] imm);
    return {imm, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, OPC_OP_IMM};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

  task automatic drain(input string tag);
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.we && e.rd != 5'd0) ref_regs[e.rd] = e.val;
      dbg_raddr = e.rd;
      #1;
      check_eq($sformatf("%s/x%0d", tag, e.rd), dbg_rdata, ref_regs[e.rd]);
    end
  endtask

  // Drive one instruction for a cycle, check the combinational writeback, then
  // park a NOP so later edges do not re-execute it.
  task automatic issue(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                       input logic exp_we, input logic [31:0] exp_val);
    exp_t e;
    @(negedge clk);
    f_instr = instr;
    f_pc    = pc;
    #1;
    check_eq($sformatf("%s/wb_en", tag), {31'b0, wb_en}, {31'b0, exp_we});
    if (exp_we) begin
      check_eq($sformatf("%s/wb_rd", tag), {27'b0, wb_rd}, {27'b0, instr[11:7]});
      check_eq($sformatf("%s/wb_data", tag), wb_data, exp_val);
    end
    e.rd  = instr[11:7];
    e.we  = exp_we;
    e.val = exp_val;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    f_instr = 32'h0;
    drain(tag);
  endtask

  task automatic check_all(input string tag);
    for (int r = 0; r < 32; r++) begin
      dbg_raddr = r[4:0];
      #1;
      check_eq($sformatf("%s/x%0d", tag, r), dbg_rdata, ref_regs[r]);
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) ref_regs[r] = '0;

    // Reset state
    #3;
    check_all("reset");
    check_eq("reset/wb_en", {31'b0, wb_en}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // lui/addi pair and li -1
    issue("lui_x1", enc_u(OPC_LUI, 5'd1, 20'h12345), 32'h0, 1'b1, 32'h12345000);
    issue("addi_x1", enc_i(F3_ADD, 5'd1, 5'd1, 12'h678), 32'h0, 1'b1, 32'h12345678);
    issue("li_x2", enc_i(F3_ADD, 5'd2, 5'd0, 12'hFFF), 32'h0, 1'b1, 32'hFFFFFFFF);

    // Fill every writable register
    for (int i = 1; i < 32; i++) begin
      issue("fill_lui", enc_u(OPC_LUI, i[4:0], 20'h11110), 32'h0, 1'b1, 32'h11110000);
      issue("fill_addi", enc_i(F3_ADD, i[4:0], i[4:0], i[11:0]), 32'h0, 1'b1,
            32'h11110000 + i);
    end
    check_all("fill");
    issue("lui_x0", enc_u(OPC_LUI, 5'd0, 20'hABCDE), 32'h0, 1'b0, 32'h0);

    // Shifts and compares around the sign bit
    issue("lui_x3", enc_u(OPC_LUI, 5'd3, 20'h80000), 32'h0, 1'b1, 32'h80000000);
    issue("srai", enc_i(F3_SR, 5'd4, 5'd3, 12'h404), 32'h0, 1'b1, 32'hF8000000);
    issue("srli", enc_i(F3_SR, 5'd5, 5'd3, 12'h004), 32'h0, 1'b1, 32'h08000000);
    issue("slt", enc_r(F7_BASE, F3_SLT, 5'd6, 5'd3, 5'd0), 32'h0, 1'b1, 32'd1);
    issue("sltu", enc_r(F7_BASE, F3_SLTU, 5'd7, 5'd3, 5'd0), 32'h0, 1'b1, 32'd0);

    // Register-register arithmetic and logic
    issue("li_x8", enc_i(F3_ADD, 5'd8, 5'd0, 12'd5), 32'h0, 1'b1, 32'd5);
    issue("li_x9", enc_i(F3_ADD, 5'd9, 5'd0, 12'd7), 32'h0, 1'b1, 32'd7);
    issue("sub", enc_r(F7_ALT, F3_ADD, 5'd10, 5'd8, 5'd9), 32'h0, 1'b1, 32'hFFFFFFFE);
    issue("add", enc_r(F7_BASE, F3_ADD, 5'd11, 5'd10, 5'd9), 32'h0, 1'b1, 32'd5);
    issue("xor", enc_r(F7_BASE, F3_XOR, 5'd13, 5'd8, 5'd9), 32'h0, 1'b1, 32'd2);
    issue("or", enc_r(F7_BASE, F3_OR, 5'd14, 5'd8, 5'd9), 32'h0, 1'b1, 32'd7);
    issue("and", enc_r(F7_BASE, F3_AND, 5'd15, 5'd8, 5'd9), 32'h0, 1'b1, 32'd5);
    issue("slli31", enc_i(F3_SLL, 5'd16, 5'd8, 12'h01F), 32'h0, 1'b1, 32'h80000000);
    issue("sra", enc_r(F7_ALT, F3_SR, 5'd17, 5'd3, 5'd9), 32'h0, 1'b1, 32'hFF000000);
    issue("sll", enc_r(F7_BASE, F3_SLL, 5'd22, 5'd9, 5'd8), 32'h0, 1'b1, 32'd224);
    issue("srl", enc_r(F7_BASE, F3_SR, 5'd23, 5'd3, 5'd8), 32'h0, 1'b1, 32'h04000000);
    issue("slti", enc_i(F3_SLT, 5'd18, 5'd3, 12'hFFF), 32'h0, 1'b1, 32'd1);
    issue("sltiu", enc_i(F3_SLTU, 5'd19, 5'd8, 12'hFFF), 32'h0, 1'b1, 32'd1);
    issue("xori", enc_i(F3_XOR, 5'd24, 5'd8, 12'hFFF), 32'h0, 1'b1, 32'hFFFFFFFA);
    issue("ori", enc_i(F3_OR, 5'd25, 5'd8, 12'h0F0), 32'h0, 1'b1, 32'h000000F5);
    issue("andi", enc_i(F3_AND, 5'd26, 5'd9, 12'h006), 32'h0, 1'b1, 32'd6);

    // AUIPC, NOP words and illegal encodings
    issue("auipc", enc_u(OPC_AUIPC, 5'd12, 20'h00001), 32'h10, 1'b1, 32'h00001010);
    issue("zero_word", 32'h00000000, 32'h0, 1'b0, 32'h0);
    issue("sw", 32'h00112023, 32'h0, 1'b0, 32'h0);
    issue("mul_f7", enc_r(7'b0000001, F3_ADD, 5'd27, 5'd8, 5'd9), 32'h0, 1'b0, 32'h0);
    issue("slli_bad_f7", enc_i(F3_SLL, 5'd28, 5'd8, 12'h401), 32'h0, 1'b0, 32'h0);
    check_all("post_nop");

    // Asynchronous reset mid-cycle, then resume
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    for (int r = 0; r < 32; r++) ref_regs[r] = '0;
    #1;
    check_all("async_rst");
    f_instr = enc_i(F3_ADD, 5'd20, 5'd0, 12'd9);
    #1;
    check_eq("rst_decode/wb_en", {31'b0, wb_en}, 32'd1);
    check_eq("rst_decode/wb_data", wb_data, 32'd9);
    @(posedge clk);
    #1;
    dbg_raddr = 5'd20;
    #1;
    check_eq("rst_no_write", dbg_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    f_instr = 32'h0;
    dbg_raddr = 5'd20;
    #1;
    check_eq("rst_release", dbg_rdata, 32'd9);
    ref_regs[20] = 32'd9;
    issue("after_rst", enc_i(F3_ADD, 5'd21, 5'd20, 12'd1), 32'h0, 1'b1, 32'd10);

    if (sb_q.size() != 0) check_eq("sb_leftover", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
